matvec_result_collector: RTL and testbench

MATVEC_RESULT_COLLECTOR -- requirements
Module: matvec_result_collector

---
 rtl/lstm_pkg.sv | 13 +
 rtl/q824_to_q412_sat.sv | 41 ++++
 rtl/matvec_result_collector.sv | 120 ++++++++++++
 tb/tb_matvec_result_collector.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared Q-format constants and state encoding for the LSTM datapath blocks.
package lstm_pkg;

   localparam int Q_DATA_WIDTH = 16;
   localparam int Q_FRAC_SHIFT = 12;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } collect_state_t;

endpackage

// File: rtl/q824_to_q412_sat.sv
// Combinational bias add, round-half-up and saturation from Q8.24 to Q4.12.
module q824_to_q412_sat
   import lstm_pkg::*;
#(
   parameter int DATA_WIDTH = Q_DATA_WIDTH,
   parameter int FRAC_SHIFT = Q_FRAC_SHIFT
) (
   input  logic signed [2*DATA_WIDTH-1:0] result,
   input  logic signed [DATA_WIDTH-1:0]   bias,
   output logic signed [DATA_WIDTH-1:0]   value,
   output logic                           saturated
);

   // Two guard bits: one for the bias add, one for the rounding constant.
   localparam int SW = 2*DATA_WIDTH + 2;
   localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (DATA_WIDTH-1)) - 1);
   localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] rounded;
   logic signed [SW-1:0] shifted;

   // NOTE: every output gets a default first so no path through this block can infer a latch.
   always_comb begin
      value     = '0;
      saturated = 1'b0;
      sum       = SW'(result) + (SW'(bias) <<< FRAC_SHIFT);
      rounded   = sum + (SW'(1) <<< (FRAC_SHIFT-1));
      shifted   = rounded >>> FRAC_SHIFT;
      if (shifted > MAX_V) begin
         value     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         saturated = 1'b1;
      end else if (shifted < MIN_V) begin
         value     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         saturated = 1'b1;
      end else begin
         value = shifted[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/matvec_result_collector.sv
// Collects per-row Q8.24 dot products, adds bias, converts to Q4.12 and buffers them for readback.
module matvec_result_collector
   import lstm_pkg::*;
#(
   parameter int MAX_ROWS   = 4,
   parameter int DATA_WIDTH = Q_DATA_WIDTH,
   parameter int FRAC_SHIFT = Q_FRAC_SHIFT
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [$clog2(MAX_ROWS):0]         num_rows,
   input  logic                              bias_write_enable,
   input  logic [$clog2(MAX_ROWS)-1:0]       bias_addr,
   input  logic signed [DATA_WIDTH-1:0]      bias_in,
   input  logic signed [2*DATA_WIDTH-1:0]    result_in,
   input  logic                              result_valid,
   input  logic [$clog2(MAX_ROWS)-1:0]       rd_addr,
   output logic signed [DATA_WIDTH-1:0]      rd_data,
   output logic                              busy,
   output logic                              done,
   output logic                              overflow
);

   localparam int AW = $clog2(MAX_ROWS);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_ROWS);

   collect_state_t              state;
   logic [AW-1:0]               row_idx;
   logic [CW-1:0]               row_count;
   logic [CW-1:0]               clamped_rows;
   logic                        last_row;
   logic                        store;
   logic                        clipped;
   logic signed [DATA_WIDTH-1:0] processed;
   logic signed [DATA_WIDTH-1:0] bias_mem [MAX_ROWS];
   logic signed [DATA_WIDTH-1:0] out_buf  [MAX_ROWS];

   assign clamped_rows = (num_rows > MAX_COUNT) ? MAX_COUNT : num_rows;
   assign last_row     = ({1'b0, row_idx} == row_count - 1'b1);
   assign store        = (state == COLLECT) && result_valid && !start;
   assign rd_data      = out_buf[rd_addr];

   // The bias is read before the edge, so a same-cycle bias write only affects later rows.
   q824_to_q412_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_sat (
      .result    (result_in),
      .bias      (bias_mem[row_idx]),
      .value     (processed),
      .saturated (clipped)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row_idx   <= '0;
         row_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else if (start) begin
         row_count <= clamped_rows;
         row_idx   <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
         if (clamped_rows == '0) begin
            state <= DONE;
            busy  <= 1'b0;
         end else begin
            state <= COLLECT;
            busy  <= 1'b1;
         end
      end else begin
         case (state)
            COLLECT: begin
               if (result_valid) begin
                  if (clipped) overflow <= 1'b1;
                  row_idx <= row_idx + 1'b1;
                  if (last_row) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            // An empty collection arrives here with done low and raises it one cycle later.
            DONE: begin
               if (done) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: both buffers are reset explicitly because rows never written since reset must read back 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_ROWS; i++) begin
            bias_mem[i] <= '0;
            out_buf[i]  <= '0;
         end
      end else begin
         if (bias_write_enable) bias_mem[bias_addr] <= bias_in;
         if (store) out_buf[row_idx] <= processed;
      end
   end

endmodule

// File: tb/tb_matvec_result_collector.sv
// Scoreboard bench: stimulus pushes expected buffer images, a monitor checks them on done or on audit.
module tb_matvec_result_collector;

   localparam int MAX_ROWS = 4;
   localparam int DW       = 16;

   typedef struct {
      int vals [MAX_ROWS];
      bit ovf;
      bit audit;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [2:0]           num_rows = '0;
   logic                 bias_write_enable = 1'b0;
   logic [1:0]           bias_addr = '0;
   logic signed [DW-1:0] bias_in = '0;
   logic signed [2*DW-1:0] result_in = '0;
   logic                 result_valid = 1'b0;
   logic [1:0]           rd_addr;
   logic signed [DW-1:0] rd_data;
   logic                 busy;
   logic                 done;
   logic                 overflow;

   int   n_checks = 0;
   int   n_errors = 0;
   int   audit_cnt = 0;
   int   audit_seen = 0;
   bit   prev_done = 1'b0;
   exp_t exp_q [$];
   int   ref_buf  [MAX_ROWS];
   int   ref_bias [MAX_ROWS];
   bit   ref_ovf;
   int   stim [MAX_ROWS];

   matvec_result_collector #(
      .MAX_ROWS   (MAX_ROWS),
      .DATA_WIDTH (DW),
      .FRAC_SHIFT (12)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .num_rows          (num_rows),
      .bias_write_enable (bias_write_enable),
      .bias_addr         (bias_addr),
      .bias_in           (bias_in),
      .result_in         (result_in),
      .result_valid      (result_valid),
      .rd_addr           (rd_addr),
      .rd_data           (rd_data),
      .busy              (busy),
      .done              (done),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference: value = round_half_up((r + b*2^12) / 2^12), clipped to 16-bit signed.
   function automatic int proc(input int r, input int b, output bit clip);
      longint s, q;
      s = longint'(r) + longint'(b) * 4096 + 2048;
      if (s >= 0) q = s / 4096;
      else        q = -((-s + 4095) / 4096);
      clip = 1'b1;
      if (q > 32767)  return 32767;
      if (q < -32768) return -32768;
      clip = 1'b0;
      return int'(q);
   endfunction

   function automatic int rand_result();
      case ($urandom_range(0, 2))
         0:       return int'($urandom);
         1:       return int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'sh0800_0000;
         default: return int'($urandom_range(0, 32'h3FFF)) - 32'sh2000;
      endcase
   endfunction

   function automatic int rand_bias();
      logic [15:0] t;
      t = 16'($urandom);
      return int'($signed(t));
   endfunction

   task automatic wait_drain();
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check("scoreboard_drain", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk);
   endtask

   task automatic push_audit();
      exp_t e;
      e.vals  = ref_buf;
      e.ovf   = ref_ovf;
      e.audit = 1'b1;
      exp_q.push_back(e);
      audit_cnt++;
   endtask

   task automatic write_bias(input int addr, input int val);
      @(posedge clk); #1;
      bias_write_enable = 1'b1;
      bias_addr         = 2'(addr);
      bias_in           = 16'(val);
      @(posedge clk); #1;
      bias_write_enable = 1'b0;
      ref_bias[addr]    = val;
   endtask

   // Runs one collection of stim[] rows; the expected image is pushed before the start pulse.
   task automatic collect(input int n_req, input bit valid_on_start, input bit bias_clash,
                          input int clash_val, input bit rand_gaps);
      int   n;
      int   gaps;
      bit   c;
      exp_t e;
      n       = (n_req > MAX_ROWS) ? MAX_ROWS : n_req;
      ref_ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         ref_buf[i] = proc(stim[i], ref_bias[i], c);
         if (c) ref_ovf = 1'b1;
         if (bias_clash && i == 0) ref_bias[0] = clash_val;
      end
      e.vals  = ref_buf;
      e.ovf   = ref_ovf;
      e.audit = 1'b0;
      exp_q.push_back(e);

      @(posedge clk); #1;
      start    = 1'b1;
      num_rows = 3'(n_req);
      if (valid_on_start) begin
         result_valid = 1'b1;
         result_in    = 32'sh1400_0000;
      end
      @(posedge clk); #1;
      start        = 1'b0;
      result_valid = 1'b0;
      check("busy_after_start", busy, (n > 0) ? 1 : 0);
      for (int i = 0; i < n; i++) begin
         gaps = rand_gaps ? int'($urandom_range(0, 2)) : 0;
         repeat (gaps) begin
            result_in = int'($urandom);
            @(posedge clk); #1;
         end
         result_valid = 1'b1;
         result_in    = stim[i];
         if (bias_clash && i == 0) begin
            bias_write_enable = 1'b1;
            bias_addr         = 2'd0;
            bias_in           = 16'(clash_val);
         end
         @(posedge clk); #1;
         result_valid      = 1'b0;
         bias_write_enable = 1'b0;
      end
      wait_drain();
   endtask

   // Monitor: compares the whole buffer image whenever done pulses or an audit is requested.
   initial begin
      exp_t e;
      rd_addr = '0;
      forever begin
         @(negedge clk);
         if (prev_done) check("done_single_cycle", done, 0);
         prev_done = done;
         if (done || audit_cnt != audit_seen) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               e = exp_q.pop_front();
               if (e.audit) audit_seen++;
               check("done_flag", done, e.audit ? 0 : 1);
               check("overflow", overflow, e.ovf);
               check("busy_when_idle", busy, 0);
               for (int r = 0; r < MAX_ROWS; r++) begin
                  rd_addr = 2'(r);
                  #1;
                  check($sformatf("rd_data[%0d]", r), rd_data, e.vals[r]);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < MAX_ROWS; i++) begin
         ref_buf[i]  = 0;
         ref_bias[i] = 0;
      end
      ref_ovf = 1'b0;

      #23;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst_n = 1'b1;
      push_audit();
      wait_drain();

      // Unit results with zero bias.
      stim = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
      collect(4, 1'b0, 1'b0, 0, 1'b0);

      // Bias 1.0 on row 0 plus 1.5 -> 2.5.
      write_bias(0, 32'h1000);
      stim[0] = 32'h0180_0000;
      collect(1, 1'b0, 1'b0, 0, 1'b0);
      write_bias(0, 0);

      // Half-LSB rounding boundary.
      stim[0] = 32'h0000_0800;
      stim[1] = 32'h0000_07FF;
      collect(2, 1'b0, 1'b0, 0, 1'b0);

      // Positive and negative saturation.
      stim[0] = 32'h1400_0000;
      stim[1] = -32'sh0A00_0000;
      collect(2, 1'b0, 1'b0, 0, 1'b0);

      // Results outside COLLECT must leave buffer and sticky flag alone.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         result_valid = 1'b1;
         result_in    = (i == 1) ? -32'sh1400_0000 : 32'sh1400_0000;
      end
      @(posedge clk); #1;
      result_valid = 1'b0;
      push_audit();
      wait_drain();

      // Empty collection: done exactly two cycles after start, overflow cleared.
      begin
         exp_t e;
         ref_ovf = 1'b0;
         e.vals  = ref_buf;
         e.ovf   = 1'b0;
         e.audit = 1'b0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         start    = 1'b1;
         num_rows = 3'd0;
         @(posedge clk); #1;
         start = 1'b0;
         check("zero_rows_busy", busy, 0);
         @(negedge clk);
         check("zero_rows_done_early", done, 0);
         @(negedge clk);
         check("zero_rows_done", done, 1);
         wait_drain();
      end

      // Result coincident with start is discarded.
      stim = '{32'h0010_0000, -32'sh0020_0000, 32'h0030_0000, 32'h0};
      collect(3, 1'b1, 1'b0, 0, 1'b0);

      // Row count above MAX_ROWS is clamped.
      stim = '{32'h0050_0000, 32'h0060_0000, 32'h0070_0000, 32'h0080_0000};
      collect(7, 1'b0, 1'b0, 0, 1'b0);

      // Bias write to the row being consumed uses the old bias.
      write_bias(0, 32'h0800);
      stim[0] = 32'h0100_0000;
      collect(1, 1'b0, 1'b1, 32'h2000, 1'b0);

      // Randomized collections.
      for (int t = 0; t < 40; t++) begin
         int n_req;
         write_bias(int'($urandom_range(0, 3)), rand_bias());
         for (int i = 0; i < MAX_ROWS; i++) stim[i] = rand_result();
         n_req = int'($urandom_range(0, 7));
         collect(n_req, 1'($urandom), (n_req > 0) ? 1'($urandom) : 1'b0, rand_bias(), 1'b1);
      end

      // Reset after two of four rows: everything clears and no done follows.
      @(posedge clk); #1;
      start    = 1'b1;
      num_rows = 3'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         result_valid = 1'b1;
         result_in    = rand_result();
         @(posedge clk); #1;
      end
      result_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_mid_busy", busy, 0);
      check("reset_mid_done", done, 0);
      check("reset_mid_overflow", overflow, 0);
      for (int i = 0; i < MAX_ROWS; i++) begin
         ref_buf[i]  = 0;
         ref_bias[i] = 0;
      end
      ref_ovf = 1'b0;
      push_audit();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
